// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing.
// Latency: n/a (declarations only). Backpressure: n/a.
// Imported by uart_rx and by the planned uart_tx so both agree on encodings.
package uart_rx_pkg;

  // Default bit period in core clocks.
  localparam int UART_CLKS_PER_BIT_DEFAULT = 104;
  localparam int UART_DATA_BITS            = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for asynchronous inputs; resets to all ones (idle line).
// Latency: STAGES cycles. Backpressure: none, samples every cycle.
// Ports: i_clk, i_reset_n (sync, active-low), i_d async input, o_q synchronized output.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      stage_q <= '1;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = stage_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, byte strobe on good stop bit, strobe on framing error.
// Latency: strobe one cycle after the stop-bit sample, ~SYNC_STAGES + 9.5*CLKS_PER_BIT after the start edge.
// Backpressure: none; the consumer must take o_dat within one byte time.
// Ports: i_clk, i_reset_n (sync, active-low), i_rx (async serial line, idle high),
//        o_received_pulse, o_dat[7:0], o_frame_error, o_busy.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx,
  output logic       o_received_pulse,
  output logic [7:0] o_dat,
  output logic       o_frame_error,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  sync_ff #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_rx),
    .o_q       (rx_s)
  );

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dat_q, dat_d;
  logic             pulse_q, pulse_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dat_q   <= '0;
      pulse_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dat_q   <= dat_d;
      pulse_q <= pulse_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dat_d   = dat_q;
    pulse_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      // Re-check the start bit at its middle; a high line here was a glitch.
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Counter is now phase-aligned to bit middles, so a full period lands mid-bit.
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Leaving at stop-bit middle gives half a bit of slack for a back-to-back start.
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            dat_d   = shift_q;
            pulse_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Swallow a held-low break so it reports one framing error, not a stream of them.
      ST_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_received_pulse = pulse_q;
  assign o_dat            = dat_q;
  assign o_frame_error    = ferr_q;
  assign o_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16, SYNC_STAGES=2.
// Latency: n/a. Backpressure: n/a.
// Table of frames plus hand sequences for latency, back-to-back, glitch, break and mid-frame reset.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       pulse;
  logic       ferr;
  logic       busy;
  logic [7:0] dat;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_rx             (rx),
    .o_received_pulse (pulse),
    .o_dat            (dat),
    .o_frame_error    (ferr),
    .o_busy           (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Output monitor, sampled on the falling edge.
  int         pulse_cnt   = 0;
  int         err_cnt     = 0;
  int         overlap_cnt = 0;
  int         repeat_cnt  = 0;
  int         datchg_cnt  = 0;
  int         pulse_cyc_q[$];
  logic [7:0] pulse_dat_q[$];

  initial begin
    logic       prev_pulse;
    logic       prev_ferr;
    logic       prev_rst;
    logic [7:0] prev_dat;
    prev_pulse = 1'b0;
    prev_ferr  = 1'b0;
    prev_rst   = 1'b0;
    prev_dat   = 8'h00;
    forever begin
      @(negedge clk);
      if (pulse === 1'b1) begin
        pulse_cnt++;
        pulse_cyc_q.push_back(cyc);
        pulse_dat_q.push_back(dat);
      end
      if (ferr === 1'b1) err_cnt++;
      if (pulse === 1'b1 && ferr === 1'b1) overlap_cnt++;
      if ((pulse === 1'b1 && prev_pulse) || (ferr === 1'b1 && prev_ferr)) repeat_cnt++;
      if (rst_n && prev_rst && pulse !== 1'b1 && dat !== prev_dat) datchg_cnt++;
      prev_pulse = (pulse === 1'b1);
      prev_ferr  = (ferr === 1'b1);
      prev_rst   = rst_n;
      prev_dat   = dat;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int last_dat();
    if (pulse_dat_q.size() == 0) return -1;
    return int'(pulse_dat_q[pulse_dat_q.size()-1]);
  endfunction

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         hold_low;
    int         exp_p;
    int         exp_e;
    logic [7:0] exp_dat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0;
    int e0;
    int fall;
    int base;

    vecs[0] = '{8'h4C, 1'b1, 0,  1, 0, 8'h4C};
    vecs[1] = '{8'h00, 1'b0, 50, 0, 1, 8'h4C};
    vecs[2] = '{8'h31, 1'b1, 0,  1, 0, 8'h31};
    vecs[3] = '{8'hA5, 1'b1, 0,  1, 0, 8'hA5};
    vecs[4] = '{8'hFF, 1'b1, 0,  1, 0, 8'hFF};
    vecs[5] = '{8'h01, 1'b1, 0,  1, 0, 8'h01};
    vecs[6] = '{8'h80, 1'b1, 0,  1, 0, 8'h80};
    vecs[7] = '{8'h55, 1'b0, 0,  0, 1, 8'h80};

    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_dat",   int'(dat),   0);
    check("rst_pulse", int'(pulse), 0);
    check("rst_ferr",  int'(ferr),  0);
    check("rst_busy",  int'(busy),  0);
    tick(1);
    rst_n = 1'b1;
    tick(5);

    // Single 'L' frame with latency measurement
    p0   = pulse_cnt;
    e0   = err_cnt;
    fall = cyc;
    send_frame(8'h4C, 1'b1);
    rx = 1'b1;
    tick(20);
    @(negedge clk);
    check("L_pulses", pulse_cnt - p0, 1);
    check("L_dat", last_dat(), 8'h4C);
    check("L_ferr", err_cnt - e0, 0);
    if (pulse_cyc_q.size() > 0)
      check_range("L_latency", pulse_cyc_q[pulse_cyc_q.size()-1] - fall, 152, 156);
    else
      check_range("L_latency", -1, 152, 156);

    // Table of frames
    for (int v = 0; v < 8; v++) begin
      p0 = pulse_cnt;
      e0 = err_cnt;
      send_frame(vecs[v].b, vecs[v].stop);
      if (vecs[v].hold_low > 0) tick(vecs[v].hold_low);
      rx = 1'b1;
      tick(30);
      @(negedge clk);
      check($sformatf("vec%0d_pulses", v), pulse_cnt - p0, vecs[v].exp_p);
      check($sformatf("vec%0d_ferr", v),   err_cnt - e0,   vecs[v].exp_e);
      check($sformatf("vec%0d_dat", v),    int'(dat),      int'(vecs[v].exp_dat));
    end

    // Back-to-back 'R' then '*'
    p0   = pulse_cnt;
    base = pulse_cyc_q.size();
    send_frame(8'h52, 1'b1);
    send_frame(8'h2A, 1'b1);
    rx = 1'b1;
    tick(30);
    @(negedge clk);
    check("b2b_pulses", pulse_cnt - p0, 2);
    if (pulse_cyc_q.size() >= base + 2) begin
      check("b2b_dat0", int'(pulse_dat_q[base]),     8'h52);
      check("b2b_dat1", int'(pulse_dat_q[base + 1]), 8'h2A);
      check_range("b2b_spacing", pulse_cyc_q[base + 1] - pulse_cyc_q[base], 158, 162);
    end else begin
      check("b2b_present", pulse_cyc_q.size() - base, 2);
    end

    // Short low glitch
    p0 = pulse_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    tick(4);
    check("glitch_busy_hi", int'(busy), 1);
    rx = 1'b1;
    tick(10);
    @(negedge clk);
    check("glitch_busy_lo", int'(busy), 0);
    check("glitch_pulses", pulse_cnt - p0, 0);
    check("glitch_ferr", err_cnt - e0, 0);
    send_frame(8'hA5, 1'b1);
    rx = 1'b1;
    tick(20);
    @(negedge clk);
    check("glitch_next_pulses", pulse_cnt - p0, 1);
    check("glitch_next_dat", int'(dat), 8'hA5);

    // Break: 0x00 with stop low, line held low
    p0 = pulse_cnt;
    e0 = err_cnt;
    send_frame(8'h00, 1'b0);
    tick(50);
    rx = 1'b1;
    tick(30);
    @(negedge clk);
    check("brk_ferr", err_cnt - e0, 1);
    check("brk_pulses", pulse_cnt - p0, 0);
    check("brk_dat_kept", int'(dat), 8'hA5);
    send_frame(8'h31, 1'b1);
    rx = 1'b1;
    tick(20);
    @(negedge clk);
    check("brk_next_pulses", pulse_cnt - p0, 1);
    check("brk_next_dat", int'(dat), 8'h31);

    // Reset in the middle of data bit 3 of 0xFF
    p0 = pulse_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB + 8);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(200);
    @(negedge clk);
    check("rstmid_pulses", pulse_cnt - p0, 0);
    check("rstmid_ferr", err_cnt - e0, 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_dat", int'(dat), 8'h00);
    send_frame(8'h7E, 1'b1);
    rx = 1'b1;
    tick(20);
    @(negedge clk);
    check("rstmid_next_pulses", pulse_cnt - p0, 1);
    check("rstmid_next_dat", int'(dat), 8'h7E);

    // Whole-run strobe properties
    check("strobe_overlap", overlap_cnt, 0);
    check("strobe_repeat", repeat_cnt, 0);
    check("dat_change_no_pulse", datchg_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
